alu_responder: RTL and testbench

ALU_RESPONDER -- requirements
Module: alu_responder

---
 rtl/alu_responder.sv | 142 ++++++++++++++
 tb/tb_alu_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_responder.sv
// Handshaked ALU responder: single-cycle add/and/or/not/pass and a WIDTH-cycle shift-add multiply.
// Define ALU_FLAGS_EN to add the registered rsp_zero / rsp_carry result flags.
module alu_responder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_carry
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef ALU_FLAGS_EN
  // Full-width product is kept so the carry flag can see bits above WIDTH-1.
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif
  localparam logic [2:0]       OP_ADD   = 3'b000;
  localparam logic [2:0]       OP_MUL   = 3'b001;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mul_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] alu_res;

  function automatic logic [WIDTH-1:0] alu_eval(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

`ifdef ALU_FLAGS_EN
  function automatic logic add_carry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH];
  endfunction
`endif

  assign req_ready = (state == IDLE);
  assign alu_res   = alu_eval(req_op, req_a, req_b);
  // One partial product per cycle: operand a weighted by bit cnt of operand b.
  assign mul_next  = acc + (op_b[cnt] ? (ACC_W'(op_a) << cnt) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
`ifdef ALU_FLAGS_EN
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_a <= req_a;
            op_b <= req_b;
            busy <= 1'b1;
            if (req_op == OP_MUL) begin
              acc   <= '0;
              cnt   <= '0;
              state <= MUL;
            end else begin
              rsp_data  <= alu_res;
              rsp_valid <= 1'b1;
              state     <= DONE;
`ifdef ALU_FLAGS_EN
              rsp_zero  <= (alu_res == '0);
              rsp_carry <= (req_op == OP_ADD) && add_carry(req_a, req_b);
`endif
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            rsp_data  <= mul_next[WIDTH-1:0];
            rsp_valid <= 1'b1;
            state     <= DONE;
`ifdef ALU_FLAGS_EN
            rsp_zero  <= (mul_next[WIDTH-1:0] == '0);
            rsp_carry <= |mul_next[ACC_W-1:WIDTH];
`endif
          end
        end
        DONE: begin
          // Returning to IDLE here blocks acceptance on this same edge.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_responder.sv
// Bench for alu_responder: directed vector table, randomized ops against an arithmetic model, reset abort.
// Flag outputs are checked only when ALU_FLAGS_EN is defined.
module tb_alu_responder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         busy;
`ifdef ALU_FLAGS_EN
  logic         rsp_zero;
  logic         rsp_carry;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_responder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef ALU_FLAGS_EN
    ,
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry)
`endif
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           hold;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         carry;
  } res_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference for the result and its flags.
  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned mask;
    int unsigned full;
    res_t r;
    mask = (1 << W) - 1;
    full = 0;
    case (op)
      3'd0:    full = int'(a) + int'(b);
      3'd1:    full = int'(a) * int'(b);
      3'd2:    full = int'(a & b);
      3'd3:    full = int'(a | b);
      3'd4:    full = int'(~a);
      default: full = int'(a);
    endcase
    r.data  = W'(full & mask);
    r.zero  = ((full & mask) == 0);
    r.carry = (op == 3'd0 || op == 3'd1) && (full > mask);
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
    return (op == 3'd1) ? W : 0;
  endfunction

  task automatic junk_req();
    req_valid = 1'b1;
    req_op    = 3'($urandom_range(0, 7));
    req_a     = W'($urandom);
    req_b     = W'($urandom);
  endtask

  // Issue one operation at a negedge, then follow it to completion.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int hold);
    int j;
`ifdef ALU_FLAGS_EN
    res_t m;
    m = model(op, a, b);
`endif
    rsp_ready = (hold == 0);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    junk_req();
    j = 0;
    while (!rsp_valid && j < W + 4) begin
      chk("busy_in_mul", busy, 1);
      @(negedge clk);
      junk_req();
      j++;
    end
    chk("latency", j, exp_latency(op));
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp);
    chk("busy_done", busy, 1);
    chk("req_ready_done", req_ready, 0);
`ifdef ALU_FLAGS_EN
    chk("rsp_zero", rsp_zero, m.zero);
    chk("rsp_carry", rsp_carry, m.carry);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      junk_req();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, exp);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("released_valid", rsp_valid, 0);
    chk("released_req_ready", req_ready, 1);
    chk("released_busy", busy, 0);
    chk("data_kept", rsp_data, exp);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic seen;

    vecs[0]  = '{3'b000, 8'h01, 8'h01, 8'h02, 0};
    vecs[1]  = '{3'b001, 8'h02, 8'h03, 8'h06, 0};
    vecs[2]  = '{3'b001, 8'h00, 8'h03, 8'h00, 0};
    vecs[3]  = '{3'b000, 8'hFF, 8'h02, 8'h01, 0};
    vecs[4]  = '{3'b001, 8'h10, 8'h10, 8'h00, 0};
    vecs[5]  = '{3'b100, 8'h08, 8'h0E, 8'hF7, 0};
    vecs[6]  = '{3'b111, 8'h01, 8'h03, 8'h01, 0};
    vecs[7]  = '{3'b010, 8'h06, 8'h05, 8'h04, 0};
    vecs[8]  = '{3'b011, 8'h09, 8'h06, 8'h0F, 0};
    vecs[9]  = '{3'b000, 8'h80, 8'h80, 8'h00, 5};
    vecs[10] = '{3'b001, 8'hFF, 8'hFF, 8'h01, 5};
    vecs[11] = '{3'b101, 8'h5A, 8'h00, 8'h5A, 1};
    vecs[12] = '{3'b110, 8'hA5, 8'hFF, 8'hA5, 2};
    vecs[13] = '{3'b001, 8'h0D, 8'h0B, 8'h8F, 3};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      r  = model(op, a, b);
      run_op(op, a, b, r.data, $urandom_range(0, 3));
    end

    // Reset in the middle of a multiply, with a nonzero result still on rsp_data.
    run_op(3'b000, 8'h33, 8'h11, 8'h44, 0);
    req_valid = 1'b1;
    req_op    = 3'b001;
    req_a     = 8'h05;
    req_b     = 8'h07;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    chk("no_rsp_after_abort", seen, 0);
    run_op(3'b000, 8'h00, 8'h01, 8'h01, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
